// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [63:0] ZERO_WORD    = '0;
  localparam int          NOP_REG_ADDR = 0;

  // Field idx of width w from a flat bus; caller truncates to the real width (w <= 64).
  function automatic logic [63:0] get_field(input logic [1023:0] bus, input int idx, input int w);
    return 64'(bus >> (idx * w));
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between the decode/writeback stages and the register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic                     init_done;
  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*ADDR_W-1:0] waddr;
  logic [NUM_WR*DATA_W-1:0] wdata;
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic                     sb_set;
  logic [ADDR_W-1:0]        sb_addr;

  modport master (input init_done, rdata, rbusy,
                  output we, waddr, wdata, re, raddr, sb_set, sb_addr);
  modport slave  (output init_done, rdata, rbusy,
                  input we, waddr, wdata, re, raddr, sb_set, sb_addr);
endinterface

// File: rtl/regfile_mp_rd_port.sv
// One read port: enable/zero-register/bypass priority mux plus scoreboard busy output.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1
) (
  input  logic                     run,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        raddr,
  input  logic [DATA_W-1:0]        arr_data,
  input  logic                     busy_bit,
  input  logic [NUM_WR-1:0]        wv,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rbusy
);

  logic              addr_ok;
  logic              hit;
  logic [DATA_W-1:0] byp;

  always_comb begin
    addr_ok = (raddr != ADDR_W'(NOP_REG_ADDR)) && (32'(raddr) < NUM_REGS);
    hit     = 1'b0;
    byp     = DATA_W'(ZERO_WORD);
    // Later ports overwrite earlier matches, so the highest-numbered writer wins.
    for (int p = 0; p < NUM_WR; p++) begin
      if (wv[p] && (ADDR_W'(get_field(1024'(waddr), p, ADDR_W)) == raddr)) begin
        hit = 1'b1;
        byp = DATA_W'(get_field(1024'(wdata), p, DATA_W));
      end
    end
    if (!run || !re || !addr_ok)
      rdata = DATA_W'(ZERO_WORD);
    else if ((BYPASS != 0) && hit)
      rdata = byp;
    else
      rdata = arr_data;
    rbusy = run && re && addr_ok && busy_bit && !((BYPASS != 0) && hit);
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with post-reset clearing sweep and per-register busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1
) (
  input logic           clk,
  input logic           rst,
  regfile_mp_if.slave   bus
);

  logic [DATA_W-1:0]        mem [NUM_REGS];
  state_t                   state;
  logic [ADDR_W-1:0]        clr_idx;
  logic                     init_done_q;
  logic                     run;
  logic [NUM_REGS-1:0]      busy;
  logic [NUM_REGS-1:0]      busy_clr;
  logic [NUM_REGS-1:0]      busy_set;
  logic [NUM_WR-1:0]        wv;
  logic [ADDR_W-1:0]        wa [NUM_WR];
  logic [DATA_W-1:0]        wd [NUM_WR];
  logic [ADDR_W-1:0]        ra [NUM_RD];
  logic [DATA_W-1:0]        arr_rd [NUM_RD];
  logic [NUM_RD-1:0]        busy_rd;
  logic [NUM_RD*DATA_W-1:0] rdata_w;
  logic [NUM_RD-1:0]        rbusy_w;

  assign run = (state == ST_RUN);

  always_comb begin
    wv       = '0;
    busy_clr = '0;
    busy_set = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      wa[p] = ADDR_W'(get_field(1024'(bus.waddr), p, ADDR_W));
      wd[p] = DATA_W'(get_field(1024'(bus.wdata), p, DATA_W));
      wv[p] = run && bus.we[p] && (wa[p] != ADDR_W'(NOP_REG_ADDR)) && (32'(wa[p]) < NUM_REGS);
      if (wv[p]) busy_clr[wa[p]] = 1'b1;
    end
    if (run && bus.sb_set && (bus.sb_addr != ADDR_W'(NOP_REG_ADDR)) && (32'(bus.sb_addr) < NUM_REGS))
      busy_set[bus.sb_addr] = 1'b1;
  end

  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      ra[r] = ADDR_W'(get_field(1024'(bus.raddr), r, ADDR_W));
      if ((ra[r] != ADDR_W'(NOP_REG_ADDR)) && (32'(ra[r]) < NUM_REGS)) begin
        arr_rd[r]  = mem[ra[r]];
        busy_rd[r] = busy[ra[r]];
      end else begin
        arr_rd[r]  = DATA_W'(ZERO_WORD);
        busy_rd[r] = 1'b0;
      end
    end
  end

  // Array has no reset; the INIT sweep is what makes its contents defined.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT)
        mem[clr_idx] <= DATA_W'(ZERO_WORD);
      else
        for (int p = 0; p < NUM_WR; p++)
          if (wv[p]) mem[wa[p]] <= wd[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_INIT;
      clr_idx     <= '0;
      init_done_q <= 1'b0;
      busy        <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          clr_idx <= clr_idx + 1'b1;
          if (32'(clr_idx) == NUM_REGS - 1) begin
            state       <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: busy <= (busy & ~busy_clr) | busy_set;
      endcase
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    regfile_rd_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .NUM_WR(NUM_WR), .BYPASS(BYPASS)
    ) u_rd (
      .run      (run),
      .re       (bus.re[r]),
      .raddr    (ra[r]),
      .arr_data (arr_rd[r]),
      .busy_bit (busy_rd[r]),
      .wv       (wv),
      .waddr    (bus.waddr),
      .wdata    (bus.wdata),
      .rdata    (rdata_w[r*DATA_W +: DATA_W]),
      .rbusy    (rbusy_w[r])
    );
  end

  assign bus.init_done = init_done_q;
  assign bus.rdata     = rdata_w;
  assign bus.rbusy     = rbusy_w;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: u0 is the bypassing 32-entry file, u1 a non-bypassing 20-entry file.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) if0 ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) if1 ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(20), .NUM_RD(2), .NUM_WR(2), .BYPASS(0))
    u1 (.clk(clk), .rst(rst), .bus(if1));

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [1:0]  re;
    logic [4:0]  ra0, ra1;
    logic        sb;
    logic [4:0]  sba;
    logic [31:0] rd0, rd1;
    logic [1:0]  rb;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                              logic [4:0] wa1, logic [31:0] wd1, logic [1:0] re,
                              logic [4:0] ra0, logic [4:0] ra1, logic sb, logic [4:0] sba,
                              logic [31:0] rd0, logic [31:0] rd1, logic [1:0] rb);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.re = re; v.ra0 = ra0; v.ra1 = ra1; v.sb = sb; v.sba = sba;
    v.rd0 = rd0; v.rd1 = rd1; v.rb = rb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drv0(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                      input logic [4:0] wa1, input logic [31:0] wd1, input logic [1:0] re,
                      input logic [4:0] ra0, input logic [4:0] ra1, input logic sb,
                      input logic [4:0] sba);
    if0.we = we; if0.waddr = {wa1, wa0}; if0.wdata = {wd1, wd0};
    if0.re = re; if0.raddr = {ra1, ra0}; if0.sb_set = sb; if0.sb_addr = sba;
  endtask

  task automatic drv1(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                      input logic [4:0] wa1, input logic [31:0] wd1, input logic [1:0] re,
                      input logic [4:0] ra0, input logic [4:0] ra1, input logic sb,
                      input logic [4:0] sba);
    if1.we = we; if1.waddr = {wa1, wa0}; if1.wdata = {wd1, wd0};
    if1.re = re; if1.raddr = {ra1, ra0}; if1.sb_set = sb; if1.sb_addr = sba;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    logic done;

    drv0(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
    drv1(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);

    //        we     wa0    wd0            wa1    wd1      re     ra0    ra1    sb    sba    rd0            rd1            rb
    tbl[0]  = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,   2'b11, 5'd1,  5'd2,  1'b0, 5'd0,  32'h0,         32'h0,         2'b00);
    tbl[1]  = mk(2'b11, 5'd5,  32'h11,       5'd5,  32'h22,  2'b11, 5'd5,  5'd6,  1'b0, 5'd0,  32'h22,        32'h0,         2'b00);
    tbl[2]  = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,   2'b11, 5'd5,  5'd5,  1'b0, 5'd0,  32'h22,        32'h22,        2'b00);
    tbl[3]  = mk(2'b01, 5'd0,  32'hDEADBEEF, 5'd0,  32'h0,   2'b11, 5'd0,  5'd5,  1'b1, 5'd0,  32'h0,         32'h22,        2'b00);
    tbl[4]  = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,   2'b11, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,         32'h0,         2'b00);
    tbl[5]  = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,   2'b11, 5'd7,  5'd7,  1'b1, 5'd7,  32'h0,         32'h0,         2'b00);
    tbl[6]  = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,   2'b01, 5'd7,  5'd7,  1'b0, 5'd0,  32'h0,         32'h0,         2'b01);
    tbl[7]  = mk(2'b01, 5'd7,  32'h77,       5'd0,  32'h0,   2'b11, 5'd7,  5'd7,  1'b1, 5'd7,  32'h77,        32'h77,        2'b00);
    tbl[8]  = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,   2'b11, 5'd7,  5'd7,  1'b0, 5'd0,  32'h77,        32'h77,        2'b11);
    tbl[9]  = mk(2'b10, 5'd0,  32'h0,        5'd7,  32'h78,  2'b11, 5'd7,  5'd7,  1'b0, 5'd0,  32'h78,        32'h78,        2'b00);
    tbl[10] = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,   2'b11, 5'd7,  5'd7,  1'b0, 5'd0,  32'h78,        32'h78,        2'b00);
    tbl[11] = mk(2'b11, 5'd9,  32'hA,        5'd10, 32'hB,   2'b11, 5'd9,  5'd10, 1'b0, 5'd0,  32'hA,         32'hB,         2'b00);
    tbl[12] = mk(2'b00, 5'd0,  32'h0,        5'd0,  32'h0,   2'b11, 5'd10, 5'd9,  1'b0, 5'd0,  32'hB,         32'hA,         2'b00);
    tbl[13] = mk(2'b01, 5'd10, 32'hC,        5'd0,  32'h0,   2'b10, 5'd9,  5'd10, 1'b0, 5'd0,  32'h0,         32'hC,         2'b00);

    // Reset release and init sweep timing on both instances.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      chk($sformatf("u0_init_done_e%0d", k), 32'(if0.init_done), (k == 32) ? 32'd1 : 32'd0);
      chk($sformatf("u1_init_done_e%0d", k), 32'(if1.init_done), (k >= 20) ? 32'd1 : 32'd0);
    end

    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      drv0(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'(a), 5'(31 - a), 1'b0, 5'd0);
      #1;
      chk($sformatf("u0_zero_rd0_a%0d", a), if0.rdata[31:0], 32'h0);
      chk($sformatf("u0_zero_rd1_a%0d", a), if0.rdata[63:32], 32'h0);
    end

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drv0(tbl[i].we, tbl[i].wa0, tbl[i].wd0, tbl[i].wa1, tbl[i].wd1, tbl[i].re,
           tbl[i].ra0, tbl[i].ra1, tbl[i].sb, tbl[i].sba);
      #1;
      chk($sformatf("vec%0d_rd0", i), if0.rdata[31:0], tbl[i].rd0);
      chk($sformatf("vec%0d_rd1", i), if0.rdata[63:32], tbl[i].rd1);
      chk($sformatf("vec%0d_rbusy", i), 32'(if0.rbusy), 32'(tbl[i].rb));
    end

    // Non-bypass instance: reads see only committed array contents.
    @(negedge clk);
    drv1(2'b01, 5'd3, 32'h9, 5'd0, 32'h0, 2'b01, 5'd3, 5'd0, 1'b0, 5'd0); #1;
    chk("nb_r3_first", if1.rdata[31:0], 32'h0);
    @(negedge clk);
    drv1(2'b01, 5'd3, 32'h5, 5'd0, 32'h0, 2'b01, 5'd3, 5'd0, 1'b0, 5'd0); #1;
    chk("nb_r3_old", if1.rdata[31:0], 32'h9);
    @(negedge clk);
    drv1(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd3, 5'd0, 1'b0, 5'd0); #1;
    chk("nb_r3_new", if1.rdata[31:0], 32'h5);
    @(negedge clk);
    drv1(2'b01, 5'd25, 32'hAB, 5'd0, 32'h0, 2'b01, 5'd25, 5'd0, 1'b1, 5'd25); #1;
    chk("nb_oor_rd_same", if1.rdata[31:0], 32'h0);
    @(negedge clk);
    drv1(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd25, 5'd0, 1'b0, 5'd0); #1;
    chk("nb_oor_rd", if1.rdata[31:0], 32'h0);
    chk("nb_oor_rbusy", 32'(if1.rbusy), 32'h0);
    @(negedge clk);
    drv1(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd6, 5'd0, 1'b1, 5'd6); #1;
    chk("nb_r6_busy_before", 32'(if1.rbusy), 32'h0);
    @(negedge clk);
    drv1(2'b10, 5'd0, 32'h0, 5'd6, 32'h66, 2'b11, 5'd6, 5'd6, 1'b0, 5'd0); #1;
    chk("nb_r6_rd_wr_cycle", if1.rdata, 64'h0);
    chk("nb_r6_busy_wr_cycle", 32'(if1.rbusy), 32'h3);
    @(negedge clk);
    drv1(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd6, 5'd6, 1'b0, 5'd0); #1;
    chk("nb_r6_rd_after", if1.rdata[63:32], 32'h66);
    chk("nb_r6_busy_after", 32'(if1.rbusy), 32'h0);

    // Mid-RUN reset on u0: contents are swept and INIT ignores traffic.
    @(negedge clk);
    drv0(2'b01, 5'd4, 32'h7, 5'd0, 32'h0, 2'b11, 5'd4, 5'd4, 1'b0, 5'd0); #1;
    chk("r4_bypass", if0.rdata[31:0], 32'h7);
    @(negedge clk);
    drv0(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd4, 5'd4, 1'b0, 5'd0); #1;
    chk("r4_array", if0.rdata[63:32], 32'h7);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_init_done_low", 32'(if0.init_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drv0(2'b01, 5'd4, 32'h1, 5'd0, 32'h0, 2'b11, 5'd4, 5'd4, 1'b1, 5'd4); #1;
    chk("init_rd_zero", if0.rdata, 64'h0);
    cnt  = 0;
    done = 1'b0;
    while (!done && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      if (if0.init_done) done = 1'b1;
      else begin
        chk($sformatf("init_rd_e%0d", cnt), if0.rdata[31:0], 32'h0);
        chk($sformatf("init_rbusy_e%0d", cnt), 32'(if0.rbusy), 32'h0);
      end
    end
    chk("reinit_seen", 32'(done), 32'h1);
    chk("reinit_edges", 32'(cnt), 32'd32);
    @(negedge clk);
    drv0(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd4, 5'd4, 1'b0, 5'd0); #1;
    chk("r4_after_reinit", if0.rdata, 64'h0);
    chk("r4_busy_after_reinit", 32'(if0.rbusy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
